chose_sel_ctrl: RTL
===================

Name: chose_sel_ctrl

Overview:
Select-line controller that drives the `c` (select) input of the downstream chose_2to1 mux from a board push-button.
- Synchronises and debounces the raw button.
- Manual mode: each debounced press toggles the select.
- Auto mode: the select alternates at a fixed period.
- Emits a one-cycle change strobe for downstream logging/LEDs.

Parameters:
- DB_CYCLES, 4: consecutive synchronised samples at the new level required to accept a button level change; legal range ≥2.
- AUTO_PERIOD, 8: cycles between automatic select toggles; legal range ≥2.
- CNT_W, 16: width of the debounce and period counters; must hold max(DB_CYCLES, AUTO_PERIOD).

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on rising clk edge.
- btn_raw  in  1  asynchronous, bouncy push-button level; 1 = pressed.
- auto_en  in  1  synchronous mode select; 1 = auto alternate, 0 = manual toggle.
- sel  out  1  registered select to the chose_2to1 `c` input.
- sel_chg  out  1  registered one-cycle strobe; high in exactly the cycles where sel holds a value different from the previous cycle.
- db_btn  out  1  registered debounced button level.

Behaviour:
- Interface: one clock, `clk`. Reset `rst_n` is synchronous and active-low.
- Reset (rst_n=0 at an edge):
  - sel=0, sel_chg=0, db_btn=0.
  - Synchroniser flops s1 and s2 = 0; debounce counter = 0; period counter = 0.
  - Reset mid-debounce or mid-period discards all progress.
- Synchroniser: two flops, s1 <= btn_raw, s2 <= s1. No other logic reads btn_raw.
- Debounce, evaluated each edge:
  - If s2 == db_btn: counter <= 0.
  - Else if counter == DB_CYCLES-1: db_btn <= s2, counter <= 0.
  - Else: counter++.
  - A level therefore needs DB_CYCLES consecutive s2 samples to be accepted. Any shorter glitch is rejected and the counter restarts.
- Press event: the edge where db_btn goes 0→1. Release (1→0) produces no event.
- Latency: btn_raw rises and stays high before edge 1; db_btn=1 and the manual sel toggle take effect at edge 2+DB_CYCLES (edge 6 at default).
- Manual mode (auto_en=0):
  - A press event toggles sel.
  - Period counter is held at 0.
- Auto mode (auto_en=1):
  - Period counter counts 0..AUTO_PERIOD-1. At AUTO_PERIOD-1 it toggles sel and wraps to 0, so sel toggles every AUTO_PERIOD cycles.
  - A press event toggles sel and clears the period counter; the press takes priority.
  - If a press and a period wrap coincide, sel toggles exactly once.
- Mode change:
  - auto_en 1→0 zeroes the period counter on the next edge.
  - auto_en 0→1 starts counting from 0, so the first auto toggle occurs AUTO_PERIOD edges later.
- sel_chg: sel_chg <= (next_sel != sel). It is high in the same cycle the new sel value is visible; it is never high for two cycles unless sel toggles on consecutive edges.
- Counter overflow cannot occur given the CNT_W constraint. Behaviour with out-of-range parameters is not required.

Decomposition:
- Shared package (lab_common_pkg):
  - Constant SEL_A = 1'b0 (mux selects a).
  - Constant SEL_B = 1'b1.
  - Default DB_CYCLES/AUTO_PERIOD values shared with other button-driven lab blocks.
- One sub-module: btn_debounce.
  - Contains the synchroniser, debounce counter, and db_btn register.
  - Outputs db_btn and a one-cycle press pulse.
  - Parameterised by DB_CYCLES and CNT_W.
  - chose_sel_ctrl instantiates it and holds the period counter, sel register, and sel_chg logic.

Test Plan:
1. Reset: rst_n=0 for 3 cycles with btn_raw=1, auto_en=1 → sel=0, sel_chg=0, db_btn=0 throughout. Release reset with btn_raw=0 → outputs stay 0.
2. Single press, defaults, auto_en=0: btn_raw=1 held from just before edge 1 → db_btn=1, sel=1, sel_chg=1 at edge 6 only. btn_raw=0 later → db_btn=0 after 6 edges; sel stays 1, no sel_chg.
3. Glitch reject: btn_raw high for 3 cycles, then low → db_btn, sel, sel_chg all remain 0. Pulse of exactly 4 stable s2 samples → accepted, sel=1.
4. Auto mode: auto_en=1 from reset release → sel toggles at edges 8, 16, 24 with a single-cycle sel_chg at each. auto_en=0 at edge 20 → no toggle at 24.
5. Press/wrap coincidence: time the press to land on the period-wrap edge (edge 8) → sel toggles once (0→1); next auto toggle at edge 16.
6. Reset mid-operation: rst_n=0 after 2 debounce counts while sel=1 → sel=0. With btn_raw still high after release → a fresh 2+DB_CYCLES edges are needed before the toggle.

Source files
------------

// File: rtl/lab_common_pkg.sv
// rtl/lab_common_pkg.sv - shared constants and defaults for button-driven lab blocks
package lab_common_pkg;

  // Select encodings for the chose_2to1 mux `c` input
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Defaults shared by blocks that debounce a board push-button
  localparam int DEF_DB_CYCLES   = 4;
  localparam int DEF_AUTO_PERIOD = 8;
  localparam int DEF_CNT_W       = 16;

  // Swap between the two mux inputs
  function automatic logic flip_sel(input logic s);
    return (s == SEL_A) ? SEL_B : SEL_A;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser, level debouncer and press pulse
module btn_debounce
  import lab_common_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic db_btn,
  output logic press
);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // The new level is taken on the edge where the counter has already seen
  // DB_CYCLES-1 differing samples and the current one still differs.
  assign accept = (s2 != db_btn) && (cnt == CNT_W'(DB_CYCLES - 1));

  // Combinational so the consumer can act on the same edge db_btn rises.
  assign press = accept && s2;

  // Synchronise btn_raw, then require a run of stable samples before changing db_btn
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      db_btn <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      if (s2 == db_btn) begin
        cnt <= '0;
      end else if (accept) begin
        db_btn <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/chose_sel_ctrl.sv
// rtl/chose_sel_ctrl.sv - select-line controller for the chose_2to1 mux
module chose_sel_ctrl
  import lab_common_pkg::*;
#(
  parameter int DB_CYCLES   = DEF_DB_CYCLES,
  parameter int AUTO_PERIOD = DEF_AUTO_PERIOD,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic auto_en,
  output logic sel,
  output logic sel_chg,
  output logic db_btn
);

  logic             press;
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] pcnt_nxt;
  logic             sel_nxt;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_raw),
    .db_btn  (db_btn),
    .press   (press)
  );

  // Next select and period count; a press wins over a period wrap so sel flips once
  always_comb begin
    sel_nxt  = sel;
    pcnt_nxt = '0;
    if (auto_en) begin
      if (press) begin
        sel_nxt = flip_sel(sel);
      end else if (pcnt == CNT_W'(AUTO_PERIOD - 1)) begin
        sel_nxt = flip_sel(sel);
      end else begin
        pcnt_nxt = pcnt + CNT_W'(1);
      end
    end else if (press) begin
      sel_nxt = flip_sel(sel);
    end
  end

  // Register select, its change strobe and the period counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel     <= SEL_A;
      sel_chg <= 1'b0;
      pcnt    <= '0;
    end else begin
      sel     <= sel_nxt;
      sel_chg <= (sel_nxt != sel);
      pcnt    <= pcnt_nxt;
    end
  end

endmodule
